// File: rtl/cm_notify_arbiter_pkg.sv
// rtl/cm_notify_arbiter_pkg.sv - shared types and helpers for the notification/error arbiter
package cm_notify_arbiter_pkg;

  // Default code width; modules with a different CODE_W build a local event type of the same shape.
  localparam int CM_CODE_W = 4;

  typedef struct packed {
    logic                 is_err;
    logic [CM_CODE_W-1:0] code;
  } cm_event_t;

  typedef enum logic {
    CM_ARB_IDLE = 1'b0,
    CM_ARB_HOLD = 1'b1
  } cm_arb_state_e;

  // Fold an index in [0, 2n) back into [0, n); works for non power-of-two channel counts.
  function automatic int cm_rr_wrap(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/cm_event_fifo.sv
// rtl/cm_event_fifo.sv - per-channel event FIFO with extra-bit full/empty pointers
module cm_event_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         drop
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         full;
  logic         push_ok;
  logic         pop_ok;

  // The MSB distinguishes a full FIFO from an empty one when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  assign head    = mem[rd_ptr[AW-1:0]];

  // Storage and pointer update; pointers wrap naturally through the extra bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/cm_notify_arbiter.sv
// rtl/cm_notify_arbiter.sv - error-first round-robin event arbiter; CM_DROP_CNT_EN adds Drop_Count
module cm_notify_arbiter
  import cm_notify_arbiter_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int CODE_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_CH-1:0]           ch_valid,
  input  logic [N_CH-1:0]           ch_is_err,
  input  logic [N_CH*CODE_W-1:0]    ch_code,
  input  logic                      out_ready,
  input  logic                      clr_ovf,
  output logic [CODE_W-1:0]         Notification,
  output logic                      Notification_Valid,
  output logic [CODE_W-1:0]         Error,
  output logic                      Error_Valid,
  output logic [$clog2(N_CH)-1:0]   Src_Ch,
  output logic [N_CH-1:0]           Overflow
`ifdef CM_DROP_CNT_EN
  ,
  output logic [15:0]               Drop_Count
`endif
);

  localparam int SW = $clog2(N_CH);
  localparam int EW = CODE_W + 1;

  logic [N_CH-1:0] empty;
  logic [N_CH-1:0] drop;
  logic [N_CH-1:0] pop;
  logic [N_CH-1:0] head_err;
  logic [EW-1:0]   head [N_CH];
  logic [N_CH-1:0] err_req;
  logic [N_CH-1:0] ntf_req;
  logic [N_CH-1:0] req;
  logic            any_req;
  logic            found;
  int              idx;
  logic [SW-1:0]   win;
  logic [SW-1:0]   rr_ptr;
  logic            load;
  cm_arb_state_e   state;
  cm_arb_state_e   state_nxt;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    cm_event_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ch_valid[g]),
      .push_data ({ch_is_err[g], ch_code[g*CODE_W +: CODE_W]}),
      .pop       (pop[g]),
      .head      (head[g]),
      .empty     (empty[g]),
      .drop      (drop[g])
    );
    assign head_err[g] = head[g][CODE_W];
  end

  // Pick the error class if any error head is waiting, then scan round-robin from rr_ptr.
  always_comb begin
    err_req = ~empty & head_err;
    ntf_req = ~empty & ~head_err;
    req     = (|err_req) ? err_req : ntf_req;
    any_req = |req;
    win     = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = cm_rr_wrap(int'(rr_ptr) + k, N_CH);
      if (!found && req[idx]) begin
        win   = SW'(idx);
        found = 1'b1;
      end
    end
  end

  // Output stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= CM_ARB_IDLE;
    else        state <= state_nxt;
  end

  // Next state and load decision; a consumed event is replaced in the same cycle when possible.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      CM_ARB_IDLE: begin
        if (any_req) begin
          load      = 1'b1;
          state_nxt = CM_ARB_HOLD;
        end
      end
      CM_ARB_HOLD: begin
        if (out_ready) begin
          load      = any_req;
          state_nxt = any_req ? CM_ARB_HOLD : CM_ARB_IDLE;
        end
      end
      default: state_nxt = CM_ARB_IDLE;
    endcase
  end

  // The winning FIFO is popped exactly when its head moves into the output registers.
  always_comb begin
    pop = '0;
    if (load) pop[win] = 1'b1;
  end

  // Output registers and round-robin pointer; the pointer moves only when an event is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Notification       <= '0;
      Notification_Valid <= 1'b0;
      Error              <= '0;
      Error_Valid        <= 1'b0;
      Src_Ch             <= '0;
      rr_ptr             <= '0;
    end else if (load) begin
      Src_Ch <= win;
      rr_ptr <= SW'(cm_rr_wrap(int'(win) + 1, N_CH));
      if (head_err[win]) begin
        Error              <= head[win][CODE_W-1:0];
        Error_Valid        <= 1'b1;
        Notification       <= '0;
        Notification_Valid <= 1'b0;
      end else begin
        Notification       <= head[win][CODE_W-1:0];
        Notification_Valid <= 1'b1;
        Error              <= '0;
        Error_Valid        <= 1'b0;
      end
    end else if ((state == CM_ARB_HOLD) && out_ready) begin
      Notification       <= '0;
      Notification_Valid <= 1'b0;
      Error              <= '0;
      Error_Valid        <= 1'b0;
      Src_Ch             <= '0;
    end
  end

  // Sticky drop flags; a drop in the clearing cycle keeps its bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       Overflow <= '0;
    else if (clr_ovf) Overflow <= drop;
    else              Overflow <= Overflow | drop;
  end

`ifdef CM_DROP_CNT_EN
  logic [4:0]  n_drop;
  logic [16:0] cnt_sum;

  // Count every dropped event this cycle; clearing restarts from this cycle's drops.
  always_comb begin
    n_drop = '0;
    for (int i = 0; i < N_CH; i++) n_drop = n_drop + 5'(drop[i]);
    cnt_sum = (clr_ovf ? 17'd0 : {1'b0, Drop_Count}) + 17'(n_drop);
  end

  // Saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Drop_Count <= '0;
    else        Drop_Count <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_cm_notify_arbiter.sv
// tb/tb_cm_notify_arbiter.sv - self-checking bench for cm_notify_arbiter
module tb_cm_notify_arbiter;

  localparam int N  = 4;
  localparam int CW = 4;
  localparam int D  = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    ch_valid;
  logic [N-1:0]    ch_is_err;
  logic [N*CW-1:0] ch_code;
  logic            out_ready;
  logic            clr_ovf;
  logic [CW-1:0]   Notification;
  logic            Notification_Valid;
  logic [CW-1:0]   Error;
  logic            Error_Valid;
  logic [1:0]      Src_Ch;
  logic [N-1:0]    Overflow;
`ifdef CM_DROP_CNT_EN
  logic [15:0]     Drop_Count;
`endif

  int checks   = 0;
  int failures = 0;

  cm_notify_arbiter #(.N_CH(N), .CODE_W(CW), .DEPTH(D)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ch_valid           (ch_valid),
    .ch_is_err          (ch_is_err),
    .ch_code            (ch_code),
    .out_ready          (out_ready),
    .clr_ovf            (clr_ovf),
    .Notification       (Notification),
    .Notification_Valid (Notification_Valid),
    .Error              (Error),
    .Error_Valid        (Error_Valid),
    .Src_Ch             (Src_Ch),
    .Overflow           (Overflow)
`ifdef CM_DROP_CNT_EN
    ,
    .Drop_Count         (Drop_Count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: queues of events (is_err*16 + code) and the presented event.
  int       q [N][$];
  bit       m_hold;
  bit       m_err;
  int       m_code;
  int       m_src;
  int       m_next;
  bit [N-1:0] m_ovf;
  int       m_drops;

  task automatic model_step();
    int win;
    bit any_err;
    int c;
    int e;
    bit [N-1:0] dr;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) q[i].delete();
      m_hold = 0; m_err = 0; m_code = 0; m_src = 0; m_next = 0; m_ovf = '0; m_drops = 0;
      return;
    end
    win = -1;
    dr  = '0;
    if (!m_hold || out_ready) begin
      any_err = 0;
      for (int i = 0; i < N; i++)
        if (q[i].size() > 0 && q[i][0] >= 16) any_err = 1;
      for (int k = 0; k < N; k++) begin
        c = (m_next + k) % N;
        if (win < 0 && q[c].size() > 0 && ((q[c][0] >= 16) == any_err)) win = c;
      end
      if (win >= 0) begin
        e      = q[win].pop_front();
        m_hold = 1;
        m_err  = (e >= 16);
        m_code = e % 16;
        m_src  = win;
        m_next = (win + 1) % N;
      end else begin
        m_hold = 0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (ch_valid[i]) begin
        if (q[i].size() < D) q[i].push_back(int'(ch_is_err[i]) * 16 + int'(ch_code[i*CW +: CW]));
        else dr[i] = 1'b1;
      end
    end
    if (clr_ovf) begin
      m_ovf   = dr;
      m_drops = $countones(dr);
    end else begin
      m_ovf   = m_ovf | dr;
      m_drops = m_drops + $countones(dr);
      if (m_drops > 65535) m_drops = 65535;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      model_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    int en, ev, ec, nc, sc;
    bit bad;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        en = (m_hold && !m_err) ? 1 : 0;
        ev = (m_hold && m_err) ? 1 : 0;
        nc = en ? m_code : 0;
        ec = ev ? m_code : 0;
        sc = m_hold ? m_src : 0;
        bad = (int'(Notification_Valid) != en) || (int'(Error_Valid) != ev) ||
              (int'(Notification) != nc) || (int'(Error) != ec) ||
              (int'(Src_Ch) != sc) || (Overflow != m_ovf);
`ifdef CM_DROP_CNT_EN
        if (int'(Drop_Count) != m_drops) bad = 1;
`endif
        checks++;
        if (bad) begin
          failures++;
          $display("FAIL cycle t=%0t actual nv=%0d n=%0d ev=%0d e=%0d src=%0d ovf=%b required nv=%0d n=%0d ev=%0d e=%0d src=%0d ovf=%b",
                   $time, Notification_Valid, Notification, Error_Valid, Error, Src_Ch, Overflow,
                   en, nc, ev, ec, sc, m_ovf);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Apply inputs at a falling edge and return at the next falling edge.
  task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] e, input logic [N*CW-1:0] c,
                     input logic rdy, input logic clr);
    ch_valid  = v;
    ch_is_err = e;
    ch_code   = c;
    out_ready = rdy;
    clr_ovf   = clr;
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_nv"}, int'(Notification_Valid), 0);
    chk({tag, "_ev"}, int'(Error_Valid), 0);
    chk({tag, "_n"}, int'(Notification), 0);
    chk({tag, "_e"}, int'(Error), 0);
    chk({tag, "_src"}, int'(Src_Ch), 0);
    chk({tag, "_ovf"}, int'(Overflow), 0);
`ifdef CM_DROP_CNT_EN
    chk({tag, "_dcnt"}, int'(Drop_Count), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int exp_src [4];
  int exp_cd  [4];

  initial begin
    rst_n = 1'b0; ch_valid = '0; ch_is_err = '0; ch_code = '0; out_ready = 1'b0; clr_ovf = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Single notification on ch0.
    cyc(4'b0001, 4'b0000, 16'h0005, 1'b1, 1'b0);
    chk("single_early_nv", int'(Notification_Valid), 0);
    cyc('0, '0, '0, 1'b1, 1'b0);
    chk("single_n", int'(Notification), 5);
    chk("single_nv", int'(Notification_Valid), 1);
    chk("single_src", int'(Src_Ch), 0);
    chk("single_ev", int'(Error_Valid), 0);
    cyc('0, '0, '0, 1'b1, 1'b0);
    chk("single_one_cycle", int'(Notification_Valid), 0);

    // Error beats a same-cycle notification.
    cyc(4'b0110, 4'b0100, 16'h0A30, 1'b1, 1'b0);
    cyc('0, '0, '0, 1'b1, 1'b0);
    chk("prio_e", int'(Error), 10);
    chk("prio_ev", int'(Error_Valid), 1);
    chk("prio_src_err", int'(Src_Ch), 2);
    chk("prio_n_zero", int'(Notification), 0);
    cyc('0, '0, '0, 1'b1, 1'b0);
    chk("prio_n", int'(Notification), 3);
    chk("prio_src_ntf", int'(Src_Ch), 1);
    chk("prio_ev_off", int'(Error_Valid), 0);
    cyc('0, '0, '0, 1'b1, 1'b0);
    chk("prio_done", int'(Notification_Valid), 0);

    // Fresh start so the round-robin pointer begins at channel 0.
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'b1111, 4'b0000, 16'h4321, 1'b1, 1'b0);
    cyc(4'b1111, 4'b0000, 16'h4321, 1'b1, 1'b0);
    chk("rr0_src", int'(Src_Ch), 0);
    chk("rr0_n", int'(Notification), 1);
    exp_src = '{1, 2, 3, 0};
    exp_cd  = '{2, 3, 4, 1};
    for (int i = 0; i < 4; i++) begin
      cyc('0, '0, '0, 1'b1, 1'b0);
      chk("rr_src", int'(Src_Ch), exp_src[i]);
      chk("rr_n", int'(Notification), exp_cd[i]);
      chk("rr_nobubble", int'(Notification_Valid), 1);
    end
    repeat (5) cyc('0, '0, '0, 1'b1, 1'b0);

    // Overflow on ch3 under backpressure: one event held, four queued, one dropped.
    for (int i = 1; i <= 6; i++) cyc(4'b1000, 4'b0000, {4'(i), 12'h000}, 1'b0, 1'b0);
    chk("ovf_flag", int'(Overflow), 8);
`ifdef CM_DROP_CNT_EN
    chk("ovf_dcnt", int'(Drop_Count), 1);
`endif
    for (int i = 0; i < 2; i++) begin
      cyc('0, '0, '0, 1'b0, 1'b0);
      chk("hold_n", int'(Notification), 1);
      chk("hold_src", int'(Src_Ch), 3);
    end
    cyc(4'b1000, 4'b0000, 16'h8000, 1'b0, 1'b1);
    chk("clr_vs_drop", int'(Overflow), 8);
    cyc('0, '0, '0, 1'b0, 1'b1);
    chk("clr_ovf", int'(Overflow), 0);
`ifdef CM_DROP_CNT_EN
    chk("clr_dcnt", int'(Drop_Count), 0);
`endif
    // Push into a full FIFO while it is popped: accepted, no overflow.
    cyc(4'b1000, 4'b0000, 16'h7000, 1'b1, 1'b0);
    chk("fullpop_ovf", int'(Overflow), 0);
    chk("fullpop_n", int'(Notification), 2);
    exp_cd = '{3, 4, 5, 7};
    for (int i = 0; i < 4; i++) begin
      cyc('0, '0, '0, 1'b1, 1'b0);
      chk("order_n", int'(Notification), exp_cd[i]);
    end
    cyc('0, '0, '0, 1'b1, 1'b0);
    chk("order_done", int'(Notification_Valid), 0);

    // Reset with three events outstanding.
    for (int i = 1; i <= 3; i++) cyc(4'b0001, 4'b0000, 16'(i), 1'b0, 1'b0);
    chk("mid_nv", int'(Notification_Valid), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc('0, '0, '0, 1'b1, 1'b0);
      chk("post_rst_nv", int'(Notification_Valid), 0);
      chk("post_rst_ev", int'(Error_Valid), 0);
    end
    cyc(4'b0001, 4'b0001, 16'h0009, 1'b1, 1'b0);
    cyc('0, '0, '0, 1'b1, 1'b0);
    chk("post_rst_e", int'(Error), 9);
    chk("post_rst_evv", int'(Error_Valid), 1);
    chk("post_rst_src", int'(Src_Ch), 0);
    repeat (3) cyc('0, '0, '0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
